// File: rtl/weight_loader.sv
// weight_loader: buffers one AXI-Stream packet of WEIGHT_DEPTH weights and
// replays it on command into a processing element's weight_in port.
module weight_loader #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int WEIGHT_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [WEIGHT_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic [WEIGHT_WIDTH-1:0] weight_in,
    output logic                    weight_in_tvalid,
    input  logic                    weight_in_tready,
    output logic                    weight_load_enable,
    input  logic                    start,
    input  logic                    clear,
    output logic                    weights_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len
);
    localparam int PTR_W = $clog2(WEIGHT_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(WEIGHT_DEPTH - 1);

    typedef enum logic [1:0] {FILL, DRAIN, READY, LOAD} state_t;

    state_t state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [WEIGHT_WIDTH-1:0] mem [WEIGHT_DEPTH];
    logic up_hs, dn_hs, last_rd, wr_en, load_go;

    assign s_axis_tready      = rst_n && (state == FILL || state == DRAIN);
    assign weight_in_tvalid   = state == LOAD;
    assign weight_load_enable = state == LOAD;
    assign busy               = state == LOAD;
    assign weights_ready      = state == READY;
    assign up_hs   = s_axis_tready && s_axis_tvalid;
    assign dn_hs   = state == LOAD && weight_in_tready;
    assign last_rd = rd_ptr == LAST;
    assign rd_nxt  = rd_ptr + 1'b1;
    assign wr_en   = up_hs && state == FILL && !clear;
    assign load_go = state == READY && start && !clear;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  state_nxt = clear ? FILL : (wr_en && wr_ptr == LAST) ? (s_axis_tlast ? READY : DRAIN) : FILL;
            DRAIN: state_nxt = (clear || (up_hs && s_axis_tlast)) ? FILL : DRAIN;
            READY: state_nxt = clear ? FILL : start ? LOAD : READY;
            LOAD:  state_nxt = (dn_hs && last_rd) ? READY : LOAD;
        endcase
    end

    // Weight storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            weight_in <= '0;
            done      <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= dn_hs && last_rd;
            if (clear && state != LOAD) begin
                wr_ptr  <= '0;
                err_len <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= (s_axis_tlast || wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                if (s_axis_tlast != (wr_ptr == LAST)) err_len <= 1'b1;
            end
            if (load_go) begin
                rd_ptr    <= '0;
                weight_in <= mem[0];
            end else if (dn_hs && !last_rd) begin
                rd_ptr    <= rd_nxt;
                weight_in <= mem[rd_nxt];
            end
        end
    end
endmodule
